// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg
// Shared definitions for the serial pattern generator:
//   - gen_state_t : FSM state encoding (IDLE, SHIFT, GAP, DONE)
//   - default widths for pattern, repeat count and gap length
//   - a couple of commonly used 4-bit patterns
package seq_gen_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int REP_W_DEF = 8;
    localparam int GAP_W_DEF = 4;

    localparam logic [3:0] PAT_1010 = 4'b1010;
    localparam logic [3:0] PAT_1011 = 4'b1011;

    // Two bits cover all four states, so there is no unreachable encoding;
    // the FSM still routes any unexpected value back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } gen_state_t;

endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg
// Loadable PAT_W-bit shift register that shifts left (MSB out first) and
// tracks which bit is currently presented through a down-counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears everything)
//   load      : load load_val and restart the bit counter at PAT_W-1
//   shift     : shift left by one and decrement the bit counter
//   load_val  : pattern to load
//   msb       : bit currently presented (register MSB)
//   last_bit  : high while the final bit of the pattern is presented
module seq_gen_shreg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb,
    output logic             last_bit
);

    localparam int CNT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] sr_q;
    logic [CNT_W-1:0] cnt_q;

    // load wins over shift so a back-to-back repeat can reload on the
    // same edge that shifts out the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= load_val;
            cnt_q <= CNT_W'(PAT_W - 1);
        end else if (shift) begin
            sr_q  <= {sr_q[PAT_W-2:0], 1'b0};
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign msb      = sr_q[PAT_W-1];
    assign last_bit = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
// Serial pattern transmitter. On start (sampled only while ready) it
// captures pat_in, max(rep_cnt,1) and gap_len, then shifts the pattern out
// MSB-first one bit per clock, repeating it with gap_len idle cycles
// between repeats, and pulses done for one cycle after the final bit.
// Optional feature macro: SEQ_GEN_ABORT_EN adds an abort input that drops
// a running frame back to IDLE on the next edge without a done pulse.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : transmit request (ignored while busy, not queued)
//   pat_in     : pattern, MSB sent first
//   rep_cnt    : repetition count, 0 behaves as 1
//   gap_len    : idle cycles between repetitions, 0 = back-to-back
//   abort      : (SEQ_GEN_ABORT_EN only) cancel frame in SHIFT/GAP
//   ready      : high in IDLE
//   x, x_valid : serial bit and its qualifier
//   done       : one-cycle pulse after the last bit
//   dbg_state  : current FSM state for observation
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1; start on any other edge is dropped.
// All outputs decode only flops (state and shift register), so reset
// forces them to their idle values immediately.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int REP_W = REP_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap_len,
`ifdef SEQ_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic [1:0]       dbg_state
);

    gen_state_t state_q, state_d;

    logic [PAT_W-1:0] pat_q;
    logic [REP_W-1:0] rep_q;      // repetitions still to send, incl. current
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt_q;  // idle cycles left in the current gap

    logic             sh_load;
    logic             sh_shift;
    logic [PAT_W-1:0] sh_load_val;
    logic             sh_msb;
    logic             sh_last;

    logic             capture;
    logic             rep_dec;
    logic             gap_start;
    logic             gap_dec;
    logic             abort_hit;

`ifdef SEQ_GEN_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    seq_gen_shreg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_val (sh_load_val),
        .msb      (sh_msb),
        .last_bit (sh_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_load_val = pat_q;
        capture     = 1'b0;
        rep_dec     = 1'b0;
        gap_start   = 1'b0;
        gap_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    capture     = 1'b1;
                    sh_load     = 1'b1;
                    sh_load_val = pat_in;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    if (rep_q > REP_W'(1)) begin
                        rep_dec = 1'b1;
                        if (gap_q != '0) begin
                            gap_start = 1'b1;
                            state_d   = GAP;
                        end else begin
                            // Reload on this edge: next repeat has no bubble.
                            sh_load = 1'b1;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                gap_dec = 1'b1;
                if (gap_cnt_q <= GAP_W'(1)) begin
                    sh_load = 1'b1;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_hit && (state_q == SHIFT || state_q == GAP)) begin
            state_d   = IDLE;
            sh_load   = 1'b0;
            sh_shift  = 1'b0;
            rep_dec   = 1'b0;
            gap_start = 1'b0;
            gap_dec   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            if (capture) begin
                pat_q <= pat_in;
                rep_q <= (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
                gap_q <= gap_len;
            end else if (rep_dec) begin
                rep_q <= rep_q - 1'b1;
            end

            if (gap_start) begin
                gap_cnt_q <= gap_q;
            end else if (gap_dec) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end
        end
    end

    assign ready     = (state_q == IDLE);
    assign x_valid   = (state_q == SHIFT);
    assign x         = x_valid & sh_msb;
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule
